// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: March-style built-in self test controller for a synchronous
// single-port-pair RAM with one-cycle read latency.
// Algorithm: M0 up(w P); M1 up(r P, w ~P); M2 down(r ~P, w P); M3 down(r P).
// Each read is compared in the cycle after it is issued, so every read state
// is followed by a compare state (M1_WR, M2_WR, M3_CHK) on the same address.
module ram_bist_ctrl #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 32,
  parameter int ADDRESS = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_pattern,
  input  logic               i_ready,
  input  logic [WIDTH-1:0]   i_rd_data,
  output logic               o_cs,
  output logic               o_valid,
  output logic               o_wr_en,
  output logic [ADDRESS-1:0] o_wr_addr,
  output logic [WIDTH-1:0]   o_wr_data,
  output logic               o_rd_en,
  output logic [ADDRESS-1:0] o_rd_addr,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [7:0]         o_err_cnt,
  output logic [ADDRESS-1:0] o_fail_addr,
  output logic [WIDTH-1:0]   o_fail_data
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    M0_WR  = 4'd1,
    M1_RD  = 4'd2,
    M1_WR  = 4'd3,
    M2_RD  = 4'd4,
    M2_WR  = 4'd5,
    M3_RD  = 4'd6,
    M3_CHK = 4'd7,
    DONE   = 4'd8
  } state_t;

  localparam logic [ADDRESS-1:0] LAST_ADDR = ADDRESS'(DEPTH - 1);
  localparam logic [ADDRESS-1:0] ONE_ADDR  = ADDRESS'(1);

  state_t               r_state;
  state_t               w_next;
  logic [ADDRESS-1:0]   r_addr;
  logic [WIDTH-1:0]     r_pat;
  logic [7:0]           r_err_cnt;
  logic                 r_fail_seen;
  logic [ADDRESS-1:0]   r_fail_addr;
  logic [WIDTH-1:0]     r_fail_data;

  logic                 w_accept;
  logic                 w_addr_last;
  logic                 w_addr_first;
  logic                 w_chk;
  logic [WIDTH-1:0]     w_expect;
  logic                 w_mismatch;

  // Error counter increment that sticks at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    if (cnt == 8'hFF) begin
      return cnt;
    end
    return cnt + 8'd1;
  endfunction

  assign w_accept     = ((r_state == IDLE) || (r_state == DONE)) && i_start && i_ready;
  assign w_addr_last  = (r_addr == LAST_ADDR);
  assign w_addr_first = (r_addr == '0);

  // Read data returned this cycle belongs to the read issued last cycle at the
  // same address; M2 expects the inverted background written during M1.
  assign w_chk      = (r_state == M1_WR) || (r_state == M2_WR) || (r_state == M3_CHK);
  assign w_expect   = (r_state == M2_WR) ? ~r_pat : r_pat;
  assign w_mismatch = w_chk && (i_rd_data != w_expect);

  // State register; reset aborts any run in progress.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: each element ends on its boundary address and hands over to
  // the first state of the next element rather than wrapping.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = M0_WR;
      M0_WR:   if (w_addr_last) w_next = M1_RD;
      M1_RD:   w_next = M1_WR;
      M1_WR:   w_next = w_addr_last ? M2_RD : M1_RD;
      M2_RD:   w_next = M2_WR;
      M2_WR:   w_next = w_addr_first ? M3_RD : M2_RD;
      M3_RD:   w_next = M3_CHK;
      M3_CHK:  w_next = w_addr_first ? DONE : M3_RD;
      DONE:    if (w_accept) w_next = M0_WR;
      default: w_next = IDLE;
    endcase
  end

  // RAM bus and status decode; everything idles at zero outside a run.
  always_comb begin
    o_wr_en   = 1'b0;
    o_wr_addr = '0;
    o_wr_data = '0;
    o_rd_en   = 1'b0;
    o_rd_addr = '0;
    o_busy    = 1'b1;
    case (r_state)
      M0_WR: begin
        o_wr_en   = 1'b1;
        o_wr_addr = r_addr;
        o_wr_data = r_pat;
      end
      M1_RD, M2_RD, M3_RD: begin
        o_rd_en   = 1'b1;
        o_rd_addr = r_addr;
      end
      M1_WR: begin
        o_wr_en   = 1'b1;
        o_wr_addr = r_addr;
        o_wr_data = ~r_pat;
      end
      M2_WR: begin
        o_wr_en   = 1'b1;
        o_wr_addr = r_addr;
        o_wr_data = r_pat;
      end
      M3_CHK:  o_busy = 1'b1;
      default: o_busy = 1'b0;
    endcase
  end

  assign o_cs        = o_wr_en | o_rd_en;
  assign o_valid     = o_wr_en;
  assign o_done      = (r_state == DONE);
  assign o_pass      = o_done && (r_err_cnt == 8'd0);
  assign o_err_cnt   = r_err_cnt;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;

  // Address walk, pattern latch and mismatch bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_addr      <= '0;
      r_pat       <= '0;
      r_err_cnt   <= '0;
      r_fail_seen <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else if (w_accept) begin
      r_addr      <= '0;
      r_pat       <= i_pattern;
      r_err_cnt   <= '0;
      r_fail_seen <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      case (r_state)
        M0_WR:   r_addr <= w_addr_last ? '0 : r_addr + ONE_ADDR;
        M1_WR:   r_addr <= w_addr_last ? LAST_ADDR : r_addr + ONE_ADDR;
        M2_WR:   r_addr <= w_addr_first ? LAST_ADDR : r_addr - ONE_ADDR;
        M3_CHK:  r_addr <= w_addr_first ? '0 : r_addr - ONE_ADDR;
        default: r_addr <= r_addr;
      endcase
      if (w_mismatch) begin
        r_err_cnt <= sat_inc(r_err_cnt);
        if (!r_fail_seen) begin
          r_fail_seen <= 1'b1;
          r_fail_addr <= r_addr;
          r_fail_data <= i_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl: behavioural RAM with injectable stuck-at bits,
// and a March reference model that predicts the bus sequence and results.
module tb_ram_bist_ctrl;

  localparam int D = 32;
  localparam int W = 16;
  localparam int A = 5;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [W-1:0] i_pattern;
  logic         i_ready;
  logic [W-1:0] i_rd_data;
  logic         o_cs, o_valid, o_wr_en, o_rd_en, o_busy, o_done, o_pass;
  logic [A-1:0] o_wr_addr, o_rd_addr, o_fail_addr;
  logic [W-1:0] o_wr_data, o_fail_data;
  logic [7:0]   o_err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mem [D];
  logic [W-1:0] s0  [D];
  logic [W-1:0] s1  [D];

  logic [22:0]  exp_ops[$];
  int           exp_err;
  bit           exp_seen;
  logic [A-1:0] exp_faddr;
  logic [W-1:0] exp_fdata;

  ram_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDRESS(A)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_pattern(i_pattern),
    .i_ready(i_ready), .i_rd_data(i_rd_data), .o_cs(o_cs), .o_valid(o_valid),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_err_cnt(o_err_cnt), .o_fail_addr(o_fail_addr),
    .o_fail_data(o_fail_data)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] fault(input int a, input logic [W-1:0] d);
    return (d & ~s0[a]) | s1[a];
  endfunction

  // Synchronous RAM, one-cycle read latency, faulty cells applied on write.
  always @(posedge i_clk) begin
    if (o_wr_en) mem[o_wr_addr] <= fault(int'(o_wr_addr), o_wr_data);
    if (o_rd_en) i_rd_data <= mem[o_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_faults();
    for (int a = 0; a < D; a++) begin
      s0[a] = '0;
      s1[a] = '0;
    end
  endtask

  task automatic mcmp(input int a, input logic [W-1:0] got, input logic [W-1:0] want);
    if (got != want) begin
      if (exp_err < 255) exp_err++;
      if (!exp_seen) begin
        exp_seen  = 1'b1;
        exp_faddr = A'(a);
        exp_fdata = got;
      end
    end
  endtask

  // March C- style reference: one entry per cycle {wr, rd, addr, wdata}.
  task automatic build_model(input logic [W-1:0] p);
    logic [W-1:0] m [D];
    exp_ops.delete();
    exp_err = 0; exp_seen = 1'b0; exp_faddr = '0; exp_fdata = '0;
    for (int a = 0; a < D; a++) begin
      m[a] = fault(a, p);
      exp_ops.push_back({2'b10, A'(a), p});
    end
    for (int a = 0; a < D; a++) begin
      exp_ops.push_back({2'b01, A'(a), 16'h0});
      mcmp(a, m[a], p);
      m[a] = fault(a, ~p);
      exp_ops.push_back({2'b10, A'(a), ~p});
    end
    for (int a = D - 1; a >= 0; a--) begin
      exp_ops.push_back({2'b01, A'(a), 16'h0});
      mcmp(a, m[a], ~p);
      m[a] = fault(a, p);
      exp_ops.push_back({2'b10, A'(a), p});
    end
    for (int a = D - 1; a >= 0; a--) begin
      exp_ops.push_back({2'b01, A'(a), 16'h0});
      mcmp(a, m[a], p);
      exp_ops.push_back(23'h0);
    end
  endtask

  function automatic logic [22:0] obs_op();
    logic [A-1:0] ad;
    ad = o_wr_en ? o_wr_addr : (o_rd_en ? o_rd_addr : '0);
    return {o_wr_en, o_rd_en, ad, (o_wr_en ? o_wr_data : 16'h0)};
  endfunction

  function automatic logic [63:0] all_outs();
    return {2'b00, o_cs, o_valid, o_wr_en, o_rd_en, o_wr_addr, o_wr_data,
            o_rd_addr, o_busy, o_done, o_pass, o_err_cnt, o_fail_addr, o_fail_data};
  endfunction

  // One full run; glitch_at / rst_at select a cycle for a stray start or reset.
  task automatic run(input logic [W-1:0] p, input int glitch_at, input int rst_at);
    build_model(p);
    i_pattern = p; i_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 7 * D; k++) begin
      if (k == rst_at) begin
        i_rst = 1'b0;
        #1;
        chk("rst_async", all_outs(), 64'h0);
        tick();
        i_rst = 1'b1;
        tick();
        return;
      end
      chk("bus_op", 64'(obs_op()), 64'(exp_ops[k]));
      chk("bus_excl", 64'(o_wr_en & o_rd_en), 64'h0);
      chk("cs_valid", {o_cs, o_valid}, {o_wr_en | o_rd_en, o_wr_en});
      chk("busy_run", {o_busy, o_done}, 2'b10);
      i_start = (k == glitch_at);
      tick();
    end
    i_start = 1'b0;
    chk("done", {o_done, o_busy}, 2'b10);
    chk("pass", 64'(o_pass), 64'(exp_err == 0));
    chk("err_cnt", 64'(o_err_cnt), 64'(exp_err));
    chk("fail_addr", 64'(o_fail_addr), 64'(exp_faddr));
    chk("fail_data", 64'(o_fail_data), 64'(exp_fdata));
    chk("done_bus", {o_cs, o_wr_en, o_rd_en}, 3'b000);
  endtask

  initial begin
    int bad;
    int nf;
    int a;
    int b;
    i_rst = 1'b0; i_start = 1'b0; i_ready = 1'b0; i_pattern = '0;
    clear_faults();
    tick();
    i_start = 1'b1; i_ready = 1'b1;
    tick();
    chk("reset_state", all_outs(), 64'h0);
    i_start = 1'b0; i_ready = 1'b0;
    i_rst = 1'b1;
    tick();

    // Start while RAM is not ready must be ignored.
    i_start = 1'b1; i_ready = 1'b0; i_pattern = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("not_ready", {o_busy, o_cs, o_done}, 3'b000);
    end
    i_start = 1'b0;

    // Fault-free run with the reference background.
    run(16'hA5A5, -1, -1);
    chk("clean_pass", {o_pass, o_err_cnt}, {1'b1, 8'd0});
    bad = 0;
    for (int i = 0; i < D; i++) if (mem[i] !== 16'hA5A5) bad++;
    chk("ram_final", 64'(bad), 64'h0);
    for (int k = 0; k < 3; k++) tick();
    chk("done_hold", {o_done, o_pass, o_busy}, 3'b110);

    // Bit 0 of address 9 stuck at zero.
    s0[9] = 16'h0001;
    run(16'hA5A5, -1, -1);
    chk("sa_err", 64'(o_err_cnt), 64'd2);
    chk("sa_faddr", 64'(o_fail_addr), 64'd9);
    chk("sa_fdata", 64'(o_fail_data), 64'hA5A4);

    // Stray start mid-run must not disturb anything.
    run(16'hA5A5, 50, -1);
    chk("gl_err", 64'(o_err_cnt), 64'd2);
    chk("gl_faddr", 64'(o_fail_addr), 64'd9);
    chk("gl_fdata", 64'(o_fail_data), 64'hA5A4);

    // Reset in the middle of a run, then a fresh full run.
    clear_faults();
    run(16'h3C3C, -1, 100);
    chk("post_rst_idle", {o_busy, o_done, o_cs}, 3'b000);
    run(16'h3C3C, -1, -1);
    chk("post_rst_pass", 64'(o_pass), 64'h1);

    // Randomised backgrounds, stuck-at faults and stray starts.
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      nf = int'($urandom_range(0, 3));
      for (int f = 0; f < nf; f++) begin
        a = int'($urandom_range(0, D - 1));
        b = int'($urandom_range(0, W - 1));
        if ($urandom_range(0, 1) == 1) begin
          s0[a][b] = 1'b1; s1[a][b] = 1'b0;
        end else begin
          s1[a][b] = 1'b1; s0[a][b] = 1'b0;
        end
      end
      run(16'($urandom), (r % 2 == 1) ? int'($urandom_range(0, 7 * D - 1)) : -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
